// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  localparam int unsigned DEF_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  // Addressing mode as the {P,U} pair
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_e;

endpackage

// File: rtl/ldm_stm_sequencer_lsb_encoder16.sv
// 16-bit lowest-set-bit priority encoder: index of the lowest set bit plus valid.
module lsb_encoder16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (vec[i] && !valid) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list, issues one memory beat per register
// in ascending address order, and reports the base-writeback value on completion.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              P,
  input  logic              U,
  input  logic              L,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        rf_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] wb_addr
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              l_q, l_d;

  logic [3:0]        enc_idx;
  logic              enc_valid;
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] first_addr;

  lsb_encoder16 u_enc (
    .vec   (mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, reg_list[i]};
    end
  end

  assign span = ADDR_W'(cnt) * STRIDE;

  // Beats always ascend, so decrementing modes start at the bottom of the block
  always_comb begin
    first_addr = base_addr;
    case (mode_e'({P, U}))
      MODE_IA: first_addr = base_addr;
      MODE_IB: first_addr = base_addr + STRIDE;
      MODE_DA: first_addr = base_addr - span + STRIDE;
      MODE_DB: first_addr = base_addr - span;
      default: first_addr = base_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    l_d     = l_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = reg_list;
          l_d     = L;
          addr_d  = first_addr;
          wb_d    = U ? (base_addr + span) : (base_addr - span);
          state_d = (reg_list != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (mem_ack) begin
          mask_d  = mask_q & (mask_q - 16'd1);
          addr_d  = addr_q + STRIDE;
          if ((mask_q & (mask_q - 16'd1)) == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      l_q     <= l_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mem_req  = (state_q == ST_XFER) && enc_valid;
  assign mem_we   = mem_req && !l_q;
  assign rf_we    = mem_req && mem_ack && l_q;
  assign mem_addr = addr_q;
  assign rf_sel   = enc_idx;
  assign wb_addr  = wb_q;

endmodule
